// File: rtl/shfifo_burst_rd.sv
// Purpose : drains a show-ahead FIFO as sop/eop framed bursts on a valid/ready stream.
// Latency : zero-latency data pass-through; a burst starts one cycle after the start condition is seen.
// Backpress: out_rdy low holds out_vld/out_dat/out_sop/out_eop and suppresses fifo_ren.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fifo_rdat        head-of-FIFO data (show-ahead)
//   fifo_empty       FIFO empty flag
//   fifo_rcnt        FIFO occupancy (FIFO_ADDR+1 bits)
//   fifo_ren         FIFO pop, combinational, asserted on each stream handshake
//   out_vld/out_rdy  stream handshake
//   out_dat          stream data
//   out_sop/out_eop  first / last beat of the current burst
//   burst_cnt        completed bursts (wrapping)
//   short_cnt        completed timeout-triggered bursts (wrapping)
//   busy             high while a burst is in progress
//   underrun_err     sticky flag: stream was valid while the FIFO was empty
module shfifo_burst_rd #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_ADDR  = 3,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16,
  parameter int TMR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_rdat,
  input  logic                  fifo_empty,
  input  logic [FIFO_ADDR:0]    fifo_rcnt,
  output logic                  fifo_ren,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [FIFO_WIDTH-1:0] out_dat,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           burst_cnt,
  output logic [15:0]           short_cnt,
  output logic                  busy,
  output logic                  underrun_err
);

  localparam int CW = FIFO_ADDR + 1;

  localparam logic [CW-1:0]    BURST_LEN_C = CW'(BURST_LEN);
  localparam logic [CW-1:0]    ONE_C       = CW'(1);
  localparam logic [TMR_W-1:0] ONE_T       = TMR_W'(1);
  localparam bit               TMO_EN      = (TIMEOUT != 0);
  // Only meaningful when TMO_EN; the comparison is gated off otherwise.
  localparam logic [TMR_W-1:0] TMO_LAST    = TMO_EN ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [CW-1:0]    beat, beat_nxt;
  logic [CW-1:0]    len, len_nxt;
  logic             short_flag, short_nxt;
  logic             xfer;
  logic             done;

  // Data is a straight pass-through of the FIFO head; it is only
  // qualified by out_vld, so no gating is needed in IDLE.
  assign out_dat  = fifo_rdat;
  assign fifo_ren = xfer;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Next-state, datapath next values and outputs
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    beat_nxt  = beat;
    len_nxt   = len;
    short_nxt = short_flag;
    out_vld   = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    busy      = 1'b0;
    xfer      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (fifo_rcnt >= BURST_LEN_C) begin
          // A full burst always wins over a pending timeout.
          state_nxt = BURST;
          len_nxt   = BURST_LEN_C;
          short_nxt = 1'b0;
          tmr_nxt   = '0;
        end else if (!fifo_empty && TMO_EN && (tmr == TMO_LAST)) begin
          // Flush whatever is present now; later writes wait for the
          // next burst, so len never exceeds what is really stored.
          state_nxt = BURST;
          len_nxt   = fifo_rcnt;
          short_nxt = 1'b1;
          tmr_nxt   = '0;
        end else if (!fifo_empty) begin
          tmr_nxt = tmr + ONE_T;
        end else begin
          tmr_nxt = '0;
        end
      end

      BURST: begin
        out_vld = 1'b1;
        busy    = 1'b1;
        // Framing depends only on the beat index, so it stays stable
        // across stalls.
        out_sop = (beat == '0);
        out_eop = (beat == (len - ONE_C));
        xfer    = out_rdy;
        if (xfer) begin
          if (out_eop) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            done      = 1'b1;
          end else begin
            beat_nxt = beat + ONE_C;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers and statistics
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr          <= '0;
      beat         <= '0;
      len          <= '0;
      short_flag   <= 1'b0;
      burst_cnt    <= '0;
      short_cnt    <= '0;
      underrun_err <= 1'b0;
    end else begin
      tmr        <= tmr_nxt;
      beat       <= beat_nxt;
      len        <= len_nxt;
      short_flag <= short_nxt;
      if (done) begin
        burst_cnt <= burst_cnt + 16'd1;
        if (short_flag) begin
          short_cnt <= short_cnt + 16'd1;
        end
      end
      // Presenting a beat with nothing in the FIFO means the occupancy
      // view and the burst length disagreed; latch it for software.
      if (out_vld && fifo_empty) begin
        underrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shfifo_burst_rd.sv
// Bench for shfifo_burst_rd: two instances (timeout 16 and timeout disabled),
// each fed by a small show-ahead FIFO model; beats are checked against a
// scoreboard filled as words are written.
module tb_shfifo_burst_rd;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   wr_en, ren, vld, rdy, sop, eop, busy, uerr, empty, rdy_set;
  logic [1:0]   pstall, psop, peop;
  logic [W-1:0] wr_dat [2];
  logic [W-1:0] rdat   [2];
  logic [W-1:0] dat    [2];
  logic [W-1:0] pdat   [2];
  logic [W-1:0] mem    [2][8];
  logic [3:0]   wp     [2];
  logic [3:0]   rp     [2];
  logic [3:0]   rcnt   [2];
  logic [15:0]  bcnt   [2];
  logic [15:0]  scnt   [2];
  logic         tog_en, pat_rdy;
  int           k = 0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  beat_t        sb0[$];
  beat_t        sb1[$];

  // ---------------- FIFO models (show-ahead, depth 8) ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= 4'd0;
        rp[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          mem[i][wp[i][2:0]] <= wr_dat[i];
          wp[i] <= wp[i] + 4'd1;
        end
        if (ren[i]) rp[i] <= rp[i] + 4'd1;
      end
    end
  end

  assign rcnt[0]  = wp[0] - rp[0];
  assign rcnt[1]  = wp[1] - rp[1];
  assign empty[0] = (rcnt[0] == 4'd0);
  assign empty[1] = (rcnt[1] == 4'd0);
  assign rdat[0]  = mem[0][rp[0][2:0]];
  assign rdat[1]  = mem[1][rp[1][2:0]];

  // ready pattern 1,0,0,1,0,0,... for the stall test
  always @(posedge clk) begin
    #1;
    pat_rdy = (k % 3 == 0);
    k = k + 1;
  end
  assign rdy[0] = tog_en ? pat_rdy : rdy_set[0];
  assign rdy[1] = rdy_set[1];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  shfifo_burst_rd #(
    .FIFO_WIDTH(W), .FIFO_ADDR(3), .BURST_LEN(4), .TIMEOUT(16), .TMR_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rdat(rdat[0]), .fifo_empty(empty[0]), .fifo_rcnt(rcnt[0]),
    .fifo_ren(ren[0]),
    .out_vld(vld[0]), .out_rdy(rdy[0]), .out_dat(dat[0]),
    .out_sop(sop[0]), .out_eop(eop[0]),
    .burst_cnt(bcnt[0]), .short_cnt(scnt[0]),
    .busy(busy[0]), .underrun_err(uerr[0])
  );

  shfifo_burst_rd #(
    .FIFO_WIDTH(W), .FIFO_ADDR(3), .BURST_LEN(4), .TIMEOUT(0), .TMR_W(8)
  ) u_dut_nto (
    .clk(clk), .rst_n(rst_n),
    .fifo_rdat(rdat[1]), .fifo_empty(empty[1]), .fifo_rcnt(rcnt[1]),
    .fifo_ren(ren[1]),
    .out_vld(vld[1]), .out_rdy(rdy[1]), .out_dat(dat[1]),
    .out_sop(sop[1]), .out_eop(eop[1]),
    .burst_cnt(bcnt[1]), .short_cnt(scnt[1]),
    .busy(busy[1]), .underrun_err(uerr[1])
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk = n_chk + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Monitor: handshake/pop consistency, stall stability, scoreboard.
  always @(negedge clk) begin
    beat_t e;
    logic  have;
    if (!rst_n) begin
      pstall = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ren%0d", i), 64'(ren[i]), 64'(vld[i] & rdy[i]));
        if (ren[i]) chk($sformatf("pop_empty%0d", i), 64'(empty[i]), 64'd0);
        if (pstall[i]) begin
          chk($sformatf("hold_vld%0d", i), 64'(vld[i]), 64'd1);
          chk($sformatf("hold_dat%0d", i), 64'(dat[i]), 64'(pdat[i]));
          chk($sformatf("hold_sop%0d", i), 64'(sop[i]), 64'(psop[i]));
          chk($sformatf("hold_eop%0d", i), 64'(eop[i]), 64'(peop[i]));
        end
        if (vld[i] && rdy[i]) begin
          have = (i == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
          chk($sformatf("sb_has_beat%0d", i), 64'(have), 64'd1);
          if (have) begin
            if (i == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("dat%0d", i), 64'(dat[i]), 64'(e.d));
            chk($sformatf("sop%0d", i), 64'(sop[i]), 64'(e.sop));
            chk($sformatf("eop%0d", i), 64'(eop[i]), 64'(e.eop));
          end
        end
        pstall[i] = vld[i] & ~rdy[i];
        pdat[i]   = dat[i];
        psop[i]   = sop[i];
        peop[i]   = eop[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int i, input logic [W-1:0] d, input logic s, input logic e);
    beat_t b;
    b = '{d: d, sop: s, eop: e};
    if (i == 0) sb0.push_back(b);
    else        sb1.push_back(b);
    wr_dat[i] = d;
    wr_en[i]  = 1'b1;
    @(posedge clk);
    #1;
    wr_en[i]  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int i, input logic [15:0] target, input string tag);
    int n = 0;
    while (bcnt[i] !== target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bcnt[i]), 64'(target));
    cycles(2);
  endtask

  task automatic wait_vld(input int i);
    int n = 0;
    while (!vld[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    rst_n     = 1'b1;
    wr_en     = 2'b00;
    rdy_set   = 2'b11;
    tog_en    = 1'b0;
    wr_dat[0] = '0;
    wr_dat[1] = '0;
    #3 rst_n = 1'b0;
    #10;
    for (int i = 0; i < 2; i++) begin
      chk("rst_vld",  64'(vld[i]),  64'd0);
      chk("rst_sop",  64'(sop[i]),  64'd0);
      chk("rst_eop",  64'(eop[i]),  64'd0);
      chk("rst_ren",  64'(ren[i]),  64'd0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_uerr", 64'(uerr[i]), 64'd0);
      chk("rst_bcnt", 64'(bcnt[i]), 64'd0);
      chk("rst_scnt", 64'(scnt[i]), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(2);

    // 1: full burst, one IDLE cycle after occupancy reaches 4
    for (int j = 0; j < 4; j++) wr(0, 32'hA000_0000 + 32'(j), j == 0, j == 3);
    c0 = cyc;
    wait_vld(0);
    chk("t1_start_lat", 64'(cyc - c0), 64'd1);
    wait_cnt(0, 16'd1, "t1_bcnt");
    chk("t1_scnt", 64'(scnt[0]), 64'd0);

    // 2: two words, timeout flush 16 cycles after first non-empty cycle
    wr(0, 32'hB000_0000, 1'b1, 1'b0);
    c0 = cyc;
    wr(0, 32'hB000_0001, 1'b0, 1'b1);
    wait_vld(0);
    chk("t2_tmo_lat", 64'(cyc - c0), 64'd16);
    wait_cnt(0, 16'd2, "t2_bcnt");
    chk("t2_scnt", 64'(scnt[0]), 64'd1);

    // 2b: single word flush, sop and eop on the same beat
    wr(0, 32'hF000_0000, 1'b1, 1'b1);
    wait_cnt(0, 16'd3, "t2b_bcnt");
    chk("t2b_scnt", 64'(scnt[0]), 64'd2);

    // 3: full burst under ready toggling
    tog_en = 1'b1;
    for (int j = 0; j < 4; j++) wr(0, 32'hC000_0000 + 32'(j), j == 0, j == 3);
    wait_cnt(0, 16'd4, "t3_bcnt");
    tog_en = 1'b0;
    chk("t3_rcnt", 64'(rcnt[0]), 64'd0);
    chk("t3_scnt", 64'(scnt[0]), 64'd2);

    // 4: seven words -> full burst of 4 then timeout burst of 3
    for (int j = 0; j < 7; j++)
      wr(0, 32'hD000_0000 + 32'(j), (j == 0) || (j == 4), (j == 3) || (j == 6));
    wait_cnt(0, 16'd6, "t4_bcnt");
    chk("t4_scnt", 64'(scnt[0]), 64'd3);
    chk("t4_rcnt", 64'(rcnt[0]), 64'd0);
    chk("t4_sb", 64'(sb0.size()), 64'd0);

    // 5: timeout disabled -> 3 words sit forever, 4th starts a burst
    for (int j = 0; j < 3; j++) wr(1, 32'hE000_0000 + 32'(j), j == 0, 1'b0);
    cycles(40);
    chk("t5_no_burst_bcnt", 64'(bcnt[1]), 64'd0);
    chk("t5_no_burst_vld",  64'(vld[1]),  64'd0);
    chk("t5_rcnt_held",     64'(rcnt[1]), 64'd3);
    wr(1, 32'hE000_0003, 1'b0, 1'b1);
    wait_cnt(1, 16'd1, "t5_bcnt");
    chk("t5_scnt", 64'(scnt[1]), 64'd0);
    chk("t5_sb", 64'(sb1.size()), 64'd0);
    chk("uerr0", 64'(uerr[0]), 64'd0);
    chk("uerr1", 64'(uerr[1]), 64'd0);

    // 6: reset during beat 2 of a burst
    for (int j = 0; j < 4; j++) wr(0, 32'h6000_0000 + 32'(j), j == 0, j == 3);
    wait_vld(0);
    chk("t6_vld", 64'(vld[0]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_beat2_sop", 64'(sop[0]), 64'd0);
    chk("t6_beat2_eop", 64'(eop[0]), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  64'(vld[0]),  64'd0);
    chk("t6_rst_eop",  64'(eop[0]),  64'd0);
    chk("t6_rst_ren",  64'(ren[0]),  64'd0);
    chk("t6_rst_busy", 64'(busy[0]), 64'd0);
    chk("t6_rst_bcnt", 64'(bcnt[0]), 64'd0);
    chk("t6_rst_scnt", 64'(scnt[0]), 64'd0);
    chk("t6_rst_uerr", 64'(uerr[0]), 64'd0);
    chk("t6_rst_bcnt1", 64'(bcnt[1]), 64'd0);
    sb0.delete();
    sb1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycles(5);
    chk("t6_post_busy", 64'(busy[0]), 64'd0);
    chk("t6_post_vld",  64'(vld[0]),  64'd0);
    chk("t6_post_bcnt", 64'(bcnt[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
